// File: rtl/execute_md.sv
// Execute stage with forwarding muxes, ALU, single-cycle multiplier, iterative
// radix-2 divider, branch resolution and the EX/MEM pipeline register.
module execute_md #(
    parameter int XLEN = 32,
    parameter int SHW  = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flushE,
    input  logic            regwriteE,
    input  logic            memrwE,
    input  logic            bselE,
    input  logic            brunE,
    input  logic            branchE,
    input  logic            jumpE,
    input  logic [2:0]      funct3E,
    input  logic [1:0]      wbselE,
    input  logic [4:0]      aluselE,
    input  logic [1:0]      forwardAE,
    input  logic [1:0]      forwardBE,
    input  logic [4:0]      rdE,
    input  logic [XLEN-1:0] rd1E,
    input  logic [XLEN-1:0] rd2E,
    input  logic [XLEN-1:0] immE,
    input  logic [XLEN-1:0] pcE,
    input  logic [XLEN-1:0] pc4E,
    input  logic [XLEN-1:0] resultW,
    output logic            regwriteM,
    output logic            memrwM,
    output logic [1:0]      wbselM,
    output logic [4:0]      rdM,
    output logic [XLEN-1:0] alu_resM,
    output logic [XLEN-1:0] data_writeM,
    output logic [XLEN-1:0] pc4M,
    output logic            pcselE,
    output logic [XLEN-1:0] pctargetE,
    output logic            stallE
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} divState_e;

    divState_e       state_q;
    logic [SHW-1:0]  cnt_q;
    logic [XLEN-1:0] quot_q, rem_q, divisor_q;
    logic            negQ_q, negR_q, isRem_q;

    logic [XLEN-1:0] srcA, srcB_pre, srcB, aluRes, divRes;
    logic [XLEN-1:0] aMag, bMag, quot_d, rem_d;
    logic [XLEN:0]   remShift, remDiff;
    logic [2*XLEN-1:0] mulA, mulB, product;
    logic            isDiv, divSigned, isRemOp, aNeg, bNeg, divZero, divOvf;
    logic            brEq, brLt, brCond;

    always_comb begin
        case (forwardAE)
            2'b00:   srcA = rd1E;
            2'b01:   srcA = resultW;
            2'b10:   srcA = alu_resM;
            default: srcA = '0;
        endcase
        case (forwardBE)
            2'b00:   srcB_pre = rd2E;
            2'b01:   srcB_pre = resultW;
            2'b10:   srcB_pre = alu_resM;
            default: srcB_pre = '0;
        endcase
        srcB = bselE ? immE : srcB_pre;
    end

    // Operands are sign- or zero-extended to 2*XLEN so one multiplier serves all four variants.
    always_comb begin
        mulA    = {{XLEN{((aluselE == 5'd11) || (aluselE == 5'd12)) & srcA[XLEN-1]}}, srcA};
        mulB    = {{XLEN{(aluselE == 5'd11) & srcB[XLEN-1]}}, srcB};
        product = mulA * mulB;
    end

    always_comb begin
        isDiv     = (aluselE >= 5'd14) && (aluselE <= 5'd17);
        divSigned = (aluselE == 5'd14) || (aluselE == 5'd16);
        isRemOp   = (aluselE == 5'd16) || (aluselE == 5'd17);
        aNeg      = divSigned & srcA[XLEN-1];
        bNeg      = divSigned & srcB[XLEN-1];
        aMag      = aNeg ? -srcA : srcA;
        bMag      = bNeg ? -srcB : srcB;
        divZero   = (srcB == '0);
        divOvf    = divSigned && (srcA == {1'b1, {(XLEN-1){1'b0}}}) && (srcB == '1);

        remShift  = {rem_q, quot_q[XLEN-1]};
        remDiff   = remShift - {1'b0, divisor_q};
        if (!remDiff[XLEN]) begin
            rem_d  = remDiff[XLEN-1:0];
            quot_d = {quot_q[XLEN-2:0], 1'b1};
        end else begin
            rem_d  = remShift[XLEN-1:0];
            quot_d = {quot_q[XLEN-2:0], 1'b0};
        end

        if (isRem_q) divRes = negR_q ? -rem_q : rem_q;
        else         divRes = negQ_q ? -quot_q : quot_q;
    end

    assign stallE = ~flushE & (((state_q == IDLE) & isDiv) | (state_q == BUSY));

    always_comb begin
        aluRes = '0;
        case (aluselE)
            5'd0:    aluRes = srcA + srcB;
            5'd1:    aluRes = srcA - srcB;
            5'd2:    aluRes = srcA & srcB;
            5'd3:    aluRes = srcA | srcB;
            5'd4:    aluRes = srcA ^ srcB;
            5'd5:    aluRes = srcA << srcB[SHW-1:0];
            5'd6:    aluRes = srcA >> srcB[SHW-1:0];
            5'd7:    aluRes = $signed(srcA) >>> srcB[SHW-1:0];
            5'd8:    aluRes = {{(XLEN-1){1'b0}}, ($signed(srcA) < $signed(srcB))};
            5'd9:    aluRes = {{(XLEN-1){1'b0}}, (srcA < srcB)};
            5'd10:   aluRes = product[XLEN-1:0];
            5'd11, 5'd12, 5'd13: aluRes = product[2*XLEN-1:XLEN];
            5'd14, 5'd15, 5'd16, 5'd17: aluRes = divRes;
            default: aluRes = '0;
        endcase
    end

    // Special cases load the final answer directly and skip the iteration loop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            quot_q    <= '0;
            rem_q     <= '0;
            divisor_q <= '0;
            negQ_q    <= 1'b0;
            negR_q    <= 1'b0;
            isRem_q   <= 1'b0;
        end else if (flushE) begin
            state_q <= IDLE;
        end else begin
            case (state_q)
                IDLE: if (isDiv) begin
                    isRem_q <= isRemOp;
                    if (divZero) begin
                        quot_q  <= '1;
                        rem_q   <= srcA;
                        negQ_q  <= 1'b0;
                        negR_q  <= 1'b0;
                        state_q <= DONE;
                    end else if (divOvf) begin
                        quot_q  <= srcA;
                        rem_q   <= '0;
                        negQ_q  <= 1'b0;
                        negR_q  <= 1'b0;
                        state_q <= DONE;
                    end else begin
                        quot_q    <= aMag;
                        rem_q     <= '0;
                        divisor_q <= bMag;
                        negQ_q    <= aNeg ^ bNeg;
                        negR_q    <= aNeg;
                        cnt_q     <= SHW'(XLEN - 1);
                        state_q   <= BUSY;
                    end
                end
                BUSY: begin
                    quot_q <= quot_d;
                    rem_q  <= rem_d;
                    if (cnt_q == '0) state_q <= DONE;
                    else             cnt_q   <= cnt_q - 1'b1;
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regwriteM   <= 1'b0;
            memrwM      <= 1'b0;
            wbselM      <= '0;
            rdM         <= '0;
            alu_resM    <= '0;
            data_writeM <= '0;
            pc4M        <= '0;
        end else if (flushE || stallE) begin
            regwriteM <= 1'b0;
            memrwM    <= 1'b0;
            rdM       <= '0;
        end else begin
            regwriteM   <= regwriteE;
            memrwM      <= memrwE;
            wbselM      <= wbselE;
            rdM         <= rdE;
            alu_resM    <= aluRes;
            data_writeM <= srcB_pre;
            pc4M        <= pc4E;
        end
    end

    always_comb begin
        brEq = (srcA == srcB_pre);
        brLt = brunE ? (srcA < srcB_pre) : ($signed(srcA) < $signed(srcB_pre));
        case (funct3E)
            3'b000:         brCond = brEq;
            3'b001:         brCond = ~brEq;
            3'b100, 3'b110: brCond = brLt;
            3'b101, 3'b111: brCond = ~brLt;
            default:        brCond = 1'b0;
        endcase
    end

    assign pcselE    = ~flushE & ((branchE & brCond) | jumpE);
    assign pctargetE = pcE + immE;

endmodule

// File: doc/execute_md.md
EXECUTE_MD -- requirements
Module: execute_md

Interface
REQ-001 Parameter: XLEN, default 32, datapath width; legal values 32 or 64.
REQ-002 Parameter: SHW, default $clog2(XLEN), shift-amount width.
REQ-003 clk  in  1  clock; all registers on the rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 flushE  in  1  kill the EX instruction, including any divide in flight.
REQ-006 regwriteE, memrwE, bselE, brunE, branchE, jumpE  in  1 each  decoded controls.
REQ-007 funct3E  in  3  branch condition; wbselE  in  2  writeback select; aluselE  in  5  ALU/M-extension opcode.
REQ-008 forwardAE, forwardBE  in  2 each  operand source: 00 register file, 01 resultW, 10 alu_resM, 11 zero.
REQ-009 rdE  in  5  destination register; rd1E, rd2E, immE, pcE, pc4E, resultW  in  XLEN each.
REQ-010 regwriteM, memrwM  out  1; wbselM  out  2; rdM  out  5; alu_resM, data_writeM, pc4M  out  XLEN  EX/MEM register.
REQ-011 pcselE  out  1; pctargetE  out  XLEN  redirect request and target, combinational.
REQ-012 stallE  out  1  combinational; while high, upstream stages hold.

Function
REQ-013 srcA and srcB_pre SHALL be muxed per forwardAE/forwardBE; srcB SHALL be immE when bselE=1, else srcB_pre.
REQ-014 Opcodes 0-9 SHALL be ADD, SUB, AND, OR, XOR, SLL, SRL, SRA, SLT, SLTU, with shifts using srcB[SHW-1:0].
REQ-015 Opcodes 10-13 SHALL be MUL, MULH, MULHSU, MULHU, single-cycle; MUL returns the low XLEN bits and MULH* return the high XLEN bits of the 2*XLEN product.
REQ-016 Opcodes 14-17 SHALL be DIV, DIVU, REM, REMU, computed by an iterative radix-2 divider; opcodes 18-31 SHALL give result 0.
REQ-017 The divider FSM states SHALL be IDLE, BUSY, DONE.
REQ-018 IDLE->BUSY on a divide opcode; srcA/srcB and sign flags are latched in that issue cycle, and stallE=1.
REQ-019 BUSY SHALL run exactly XLEN iterations on an internal counter, with stallE=1, then go to DONE.
REQ-020 DONE SHALL drive the quotient/remainder with stallE=0; EX/MEM captures it on that edge, then the FSM goes to IDLE.
REQ-021 A normal divide SHALL therefore stall XLEN+1 cycles, with the result in alu_resM XLEN+2 edges after issue.
REQ-022 Divide by zero SHALL skip BUSY (IDLE->DONE, 1 stall cycle): quotient all-ones, remainder = dividend.
REQ-023 Signed overflow (-2^(XLEN-1) / -1) SHALL skip BUSY: quotient = dividend, remainder 0.
REQ-024 Signed divides SHALL use magnitudes, negating the quotient if the operand signs differ and the remainder to match the dividend sign.
REQ-025 While stallE=1, the EX/MEM register SHALL load a bubble: regwriteM=0, memrwM=0, rdM=0, other fields hold.
REQ-026 flushE=1 SHALL force the FSM to IDLE and load a bubble into EX/MEM on that edge; flush outranks DONE.
REQ-027 Branch compare SHALL use srcA vs srcB_pre (unsigned when brunE=1) with funct3 000 BEQ, 001 BNE, 100/110 LT, 101/111 GE, others false.
REQ-028 pcselE SHALL equal (branchE & cond) | jumpE, gated to 0 when flushE=1.
REQ-029 pctargetE SHALL be pcE+immE, modulo 2^XLEN.
REQ-030 data_writeM SHALL capture srcB_pre (forwarded rs2).

Reset
REQ-031 rst_n low SHALL asynchronously clear all EX/MEM outputs to 0, the FSM to IDLE, the counter and the latched operands to 0.
REQ-032 After reset, stallE SHALL be 0 until a divide issues.
REQ-033 Reset during BUSY SHALL abandon the divide with no partial result visible.

Verification
REQ-034 XLEN=32, DIV 100/-7 -> stallE high 33 cycles; alu_resM=-14, then REM gives 2.
REQ-035 DIVU x/0 and REM x/0 with x=0x1234 -> 1 stall cycle; results 0xFFFFFFFF and 0x1234.
REQ-036 DIV 0x80000000/-1 -> 1 stall; quotient 0x80000000; REM gives 0.
REQ-037 MULHSU -1 x 2 -> 0xFFFFFFFF with no stall; MULHU 0xFFFFFFFF squared -> 0xFFFFFFFE.
REQ-038 flushE at BUSY cycle 10 -> FSM IDLE, stallE=0 next cycle, regwriteM=0.
REQ-039 XLEN=64, DIVU 2^63/3 -> 65 stall cycles; quotient 0x2AAAAAAAAAAAAAAA.
